sap1_controller_sequencer: RTL and testbench
============================================

Name: sap1_controller_sequencer

Overview:
- Control unit for the SAP-1 datapath, sitting directly upstream of the program counter.
- A one-hot ring counter steps T1..T6 on the falling clock edge. Each state is decoded with the instruction-register opcode into the registered control word.
- The control word drives PC count/enable_output, MAR/RAM/IR/A/B/ALU/output-register strobes and the halt indication.
- All strobes are stable across the following rising edge, where datapath registers load.

Parameters:
- OPCODE_W, 4, width of instruction opcode (IR upper nibble)
- NUM_T, 6, number of ring-counter states (T1..T6)

Ports:
- clock  input  1  system clock; all state updates on negedge
- clear  input  1  synchronous, active-high reset, sampled on negedge clock
- opcode  input  OPCODE_W  IR upper nibble; valid from T4 through T6
- t_state  output  NUM_T  one-hot ring state, bit0=T1 .. bit5=T6; all-zero = T0 (post-reset idle)
- cp  output  1  PC count
- ep  output  1  PC enable_output to bus
- pc_clr_n  output  1  active-low PC clear, equal to !clear (combinational)
- lm  output  1  load MAR
- ce  output  1  RAM output enable
- li  output  1  load IR
- ei  output  1  IR operand nibble to bus
- la  output  1  load accumulator A
- ea  output  1  A to bus
- su  output  1  ALU subtract
- eu  output  1  ALU to bus
- lb  output  1  load B
- lo  output  1  load output register
- halted  output  1  HLT executed; sequencer frozen

Behaviour:
- All strobes are active-high. State and strobes are registered on negedge clock.
- The strobe value registered at a negedge is the decode of the state entered at that same edge. There is no combinational path from opcode to outputs.
- Reset (clear=1 at a negedge, from any state including halted or mid-instruction):
  - t_state=0 (T0); every strobe=0; halted=0.
  - pc_clr_n=0 for as long as clear=1.
- T0 -> T1 on the first negedge with clear=0. Then T1->T2->...->T6->T1 each negedge.
- Fetch, regardless of opcode:
  - T1: ep, lm
  - T2: cp
  - T3: ce, li
- Execute decode uses opcode sampled at the negedge entering T4, T5 and T6:
  - LDA 0000: T4 ei,lm; T5 ce,la; T6 none
  - ADD 0001: T4 ei,lm; T5 ce,lb; T6 eu,la
  - SUB 0010: T4 ei,lm; T5 ce,lb; T6 eu,su,la
  - OUT 1110: T4 ea,lo; T5 none; T6 none
  - HLT 1111: at the negedge entering T4:
    - halted<=1, t_state<=T4 (bit3), all strobes 0
    - state frozen until clear; opcode changes ignored
  - Any other opcode: NOP, all strobes 0 in T4..T6, then normal wrap to T1.
- Opcode changes during T1..T3 have no effect on outputs.
- Exactly one t_state bit is set, except in T0. At most one bus driver (ep, ce, ei, ea, eu) is asserted in any state.
- Instruction latency: 6 clocks; HLT stops at T4 of its instruction.
- NUM_T other than 6 is unsupported. Elaboration check: fail if NUM_T != 6.

Decomposition:
- Package sap1_pkg:
  - opcode constants (OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT)
  - one-hot T-state index constants
  - packed control-word type with named bit positions, shared with the datapath top level
- Sub-module sap1_ring_counter holds the one-hot T0..T6 ring with synchronous clear and freeze input.
- The parent contains microcode decode, the halt flag and output registers.

Test Plan:
- Reset then release: clear=1 for 2 negedges -> t_state=000000, all strobes 0, pc_clr_n=0, halted=0. Clear=0 -> next negedge t_state=000001, ep=lm=1, cp=0.
- LDA (opcode=0000) full cycle -> over T1..T6 the strobes are {ep,lm},{cp},{ce,li},{ei,lm},{ce,la},{} and t_state returns to 000001 on the 7th negedge.
- SUB (opcode=0010) -> T6 has eu=su=la=1, lb=0; ADD (0001) -> T6 has eu=la=1, su=0.
- HLT (opcode=1111) presented by T3 -> at the next negedge halted=1, t_state=001000, all strobes 0. Held 10 clocks with opcode toggling -> unchanged. Clear=1 -> T0, halted=0.
- Undefined opcode 0101 -> T4..T6 all strobes 0, normal wrap to T1. Opcode toggling during T1..T3 -> fetch strobes unaffected.
- Reset mid-instruction: clear=1 at the negedge entering T5 of ADD -> t_state=0, lb=ce=0, no T5 strobes ever appear. The bus-driver one-hot assertion holds throughout all tests.

Source files
------------

// File: rtl/sap1_pkg.sv
// Shared SAP-1 control definitions: opcodes, T-state encodings and the
// control-word layout used by both the sequencer and the datapath top level.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam int T1_IDX = 0;
  localparam int T2_IDX = 1;
  localparam int T3_IDX = 2;
  localparam int T4_IDX = 3;
  localparam int T5_IDX = 4;
  localparam int T6_IDX = 5;

  // One-hot ring encoding; all-zero is the idle T0 state after clear.
  typedef enum logic [5:0] {
    ST_T0 = 6'b000000,
    ST_T1 = 6'b000001,
    ST_T2 = 6'b000010,
    ST_T3 = 6'b000100,
    ST_T4 = 6'b001000,
    ST_T5 = 6'b010000,
    ST_T6 = 6'b100000
  } t_state_e;

  typedef struct packed {
    logic cp;
    logic ep;
    logic lm;
    logic ce;
    logic li;
    logic ei;
    logic la;
    logic ea;
    logic su;
    logic eu;
    logic lb;
    logic lo;
  } ctrl_word_t;

endpackage

// File: rtl/sap1_ring_counter.sv
// One-hot T0..T6 ring stepping on the falling edge, with synchronous clear
// and a freeze input that holds the current state (used for HLT).
module sap1_ring_counter
  import sap1_pkg::*;
(
  input  logic     i_clk,
  input  logic     i_clear,
  input  logic     i_freeze,
  output t_state_e o_state,
  output t_state_e o_state_next
);

  t_state_e r_state;
  t_state_e w_state_next;

  always_comb begin
    w_state_next = r_state;
    if (!i_freeze) begin
      case (r_state)
        ST_T0:   w_state_next = ST_T1;
        ST_T1:   w_state_next = ST_T2;
        ST_T2:   w_state_next = ST_T3;
        ST_T3:   w_state_next = ST_T4;
        ST_T4:   w_state_next = ST_T5;
        ST_T5:   w_state_next = ST_T6;
        ST_T6:   w_state_next = ST_T1;
        default: w_state_next = ST_T0;
      endcase
    end
  end

  always_ff @(negedge i_clk) begin
    if (i_clear) r_state <= ST_T0;
    else         r_state <= w_state_next;
  end

  assign o_state      = r_state;
  assign o_state_next = w_state_next;

endmodule

// File: rtl/sap1_controller_sequencer.sv
// SAP-1 controller/sequencer: decodes the state being entered together with
// the opcode into a registered control word, updated on the falling edge.
module sap1_controller_sequencer
  import sap1_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int NUM_T    = 6
) (
  input  logic                clock,
  input  logic                clear,
  input  logic [OPCODE_W-1:0] opcode,
  output logic [NUM_T-1:0]    t_state,
  output logic                cp,
  output logic                ep,
  output logic                pc_clr_n,
  output logic                lm,
  output logic                ce,
  output logic                li,
  output logic                ei,
  output logic                la,
  output logic                ea,
  output logic                su,
  output logic                eu,
  output logic                lb,
  output logic                lo,
  output logic                halted
);

  if (NUM_T != 6) begin : g_num_t_check
    $fatal(1, "sap1_controller_sequencer: only NUM_T == 6 is supported");
  end

  t_state_e   w_t_state;
  t_state_e   w_t_next;
  ctrl_word_t w_cw_next;
  ctrl_word_t r_cw;
  logic       r_halted;
  logic       w_halt_now;

  sap1_ring_counter u_ring (
    .i_clk        (clock),
    .i_clear      (clear),
    .i_freeze     (r_halted),
    .o_state      (w_t_state),
    .o_state_next (w_t_next)
  );

  // HLT is recognised on the same edge that enters T4, so T4 never shows strobes.
  assign w_halt_now = !r_halted && (w_t_next == ST_T4) && (opcode == OP_HLT);

  always_comb begin
    w_cw_next = '0;
    if (!r_halted && !w_halt_now) begin
      case (w_t_next)
        ST_T1: begin
          w_cw_next.ep = 1'b1;
          w_cw_next.lm = 1'b1;
        end
        ST_T2: w_cw_next.cp = 1'b1;
        ST_T3: begin
          w_cw_next.ce = 1'b1;
          w_cw_next.li = 1'b1;
        end
        ST_T4: begin
          case (opcode)
            OP_LDA, OP_ADD, OP_SUB: begin
              w_cw_next.ei = 1'b1;
              w_cw_next.lm = 1'b1;
            end
            OP_OUT: begin
              w_cw_next.ea = 1'b1;
              w_cw_next.lo = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T5: begin
          case (opcode)
            OP_LDA: begin
              w_cw_next.ce = 1'b1;
              w_cw_next.la = 1'b1;
            end
            OP_ADD, OP_SUB: begin
              w_cw_next.ce = 1'b1;
              w_cw_next.lb = 1'b1;
            end
            default: ;
          endcase
        end
        ST_T6: begin
          case (opcode)
            OP_ADD: begin
              w_cw_next.eu = 1'b1;
              w_cw_next.la = 1'b1;
            end
            OP_SUB: begin
              w_cw_next.eu = 1'b1;
              w_cw_next.su = 1'b1;
              w_cw_next.la = 1'b1;
            end
            default: ;
          endcase
        end
        default: ;
      endcase
    end
  end

  always_ff @(negedge clock) begin
    if (clear) begin
      r_cw     <= '0;
      r_halted <= 1'b0;
    end else begin
      r_cw     <= w_cw_next;
      r_halted <= r_halted | w_halt_now;
    end
  end

  assign t_state  = w_t_state;
  assign pc_clr_n = !clear;
  assign cp       = r_cw.cp;
  assign ep       = r_cw.ep;
  assign lm       = r_cw.lm;
  assign ce       = r_cw.ce;
  assign li       = r_cw.li;
  assign ei       = r_cw.ei;
  assign la       = r_cw.la;
  assign ea       = r_cw.ea;
  assign su       = r_cw.su;
  assign eu       = r_cw.eu;
  assign lb       = r_cw.lb;
  assign lo       = r_cw.lo;
  assign halted   = r_halted;

endmodule

// File: tb/tb_sap1_controller_sequencer.sv
// Bench for the SAP-1 sequencer: directed instruction walks with literal
// expectations plus randomized opcode/clear traffic against a step model.
module tb_sap1_controller_sequencer;

  localparam logic [11:0] S_EP = 12'b1000_0000_0000;
  localparam logic [11:0] S_LM = 12'b0100_0000_0000;
  localparam logic [11:0] S_CP = 12'b0010_0000_0000;
  localparam logic [11:0] S_CE = 12'b0001_0000_0000;
  localparam logic [11:0] S_LI = 12'b0000_1000_0000;
  localparam logic [11:0] S_EI = 12'b0000_0100_0000;
  localparam logic [11:0] S_LA = 12'b0000_0010_0000;
  localparam logic [11:0] S_LB = 12'b0000_0001_0000;
  localparam logic [11:0] S_EU = 12'b0000_0000_1000;
  localparam logic [11:0] S_SU = 12'b0000_0000_0100;
  localparam logic [11:0] S_EA = 12'b0000_0000_0010;
  localparam logic [11:0] S_LO = 12'b0000_0000_0001;

  localparam logic [3:0] LDA = 4'b0000;
  localparam logic [3:0] ADD = 4'b0001;
  localparam logic [3:0] SUB = 4'b0010;
  localparam logic [3:0] OUT = 4'b1110;
  localparam logic [3:0] HLT = 4'b1111;
  localparam logic [3:0] NOP = 4'b0101;

  // clock/reset block
  logic       clock = 1'b0;
  logic       clear = 1'b1;
  logic [3:0] opcode = 4'b0000;
  always #5 clock = ~clock;

  logic [5:0] t_state;
  logic cp, ep, pc_clr_n, lm, ce, li, ei, la, ea, su, eu, lb, lo, halted;
  logic [11:0] w_act;
  assign w_act = {ep, lm, cp, ce, li, ei, la, lb, eu, su, ea, lo};

  sap1_controller_sequencer #(.OPCODE_W(4), .NUM_T(6)) dut (
    .clock(clock), .clear(clear), .opcode(opcode), .t_state(t_state),
    .cp(cp), .ep(ep), .pc_clr_n(pc_clr_n), .lm(lm), .ce(ce), .li(li),
    .ei(ei), .la(la), .ea(ea), .su(su), .eu(eu), .lb(lb), .lo(lo),
    .halted(halted)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: instruction step 0 (idle) .. 6, plus a halt flag.
  function automatic logic [11:0] model_strobes(input int step, input logic [3:0] op, input bit hlt);
    logic [11:0] m;
    m = '0;
    if (hlt) return m;
    case (step)
      1: m = S_EP | S_LM;
      2: m = S_CP;
      3: m = S_CE | S_LI;
      4: if (op == LDA || op == ADD || op == SUB) m = S_EI | S_LM;
         else if (op == OUT) m = S_EA | S_LO;
      5: if (op == LDA) m = S_CE | S_LA;
         else if (op == ADD || op == SUB) m = S_CE | S_LB;
      6: if (op == ADD) m = S_EU | S_LA;
         else if (op == SUB) m = S_EU | S_SU | S_LA;
      default: m = '0;
    endcase
    return m;
  endfunction

  function automatic logic [5:0] step_onehot(input int step);
    logic [5:0] v;
    v = '0;
    if (step > 0) v[step-1] = 1'b1;
    return v;
  endfunction

  // scoreboard: {t_state, strobes, halted}
  logic [18:0] exp_q[$];
  int m_step = 0;
  bit m_halted = 0;
  bit m_valid = 0;

  always @(negedge clock) begin
    if (clear) begin
      m_step   = 0;
      m_halted = 0;
      m_valid  = 1;
    end else if (m_valid && !m_halted) begin
      m_step = (m_step == 6) ? 1 : m_step + 1;
      if (m_step == 4 && opcode == HLT) m_halted = 1;
    end
    if (m_valid) exp_q.push_back({step_onehot(m_step), model_strobes(m_step, opcode, m_halted), m_halted});
  end

  always @(posedge clock) begin
    logic [18:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("model_t_state", {26'd0, t_state}, {26'd0, e[18:13]});
      chk("model_strobes", {20'd0, w_act}, {20'd0, e[12:1]});
      chk("model_halted", {31'd0, halted}, {31'd0, e[0]});
      chk("pc_clr_n", {31'd0, pc_clr_n}, {31'd0, !clear});
      chk("bus_onehot", {31'd0, ($countones({ep, ce, ei, ea, eu}) <= 1)}, 32'd1);
    end
  end

  // driver tasks
  task automatic cycle(input logic c, input logic [3:0] op);
    clear  = c;
    opcode = op;
    @(negedge clock);
    @(posedge clock);
    #1;
  endtask

  logic [11:0] exp_seq [6];

  task automatic run_instr(input string name, input logic [3:0] op, input bit rand_fetch);
    for (int i = 0; i < 6; i++) begin
      logic [3:0] fop;
      fop = (rand_fetch && i < 3) ? 4'($urandom_range(0, 15)) : op;
      cycle(1'b0, fop);
      chk({name, "_t_state"}, {26'd0, t_state}, {26'd0, step_onehot(i + 1)});
      chk({name, "_strobes"}, {20'd0, w_act}, {20'd0, exp_seq[i]});
    end
  endtask

  initial begin
    // reset and release
    cycle(1'b1, LDA);
    cycle(1'b1, LDA);
    chk("rst_t_state", {26'd0, t_state}, 32'd0);
    chk("rst_strobes", {20'd0, w_act}, 32'd0);
    chk("rst_pc_clr_n", {31'd0, pc_clr_n}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);

    exp_seq = '{S_EP | S_LM, S_CP, S_CE | S_LI, S_EI | S_LM, S_CE | S_LA, 12'd0};
    run_instr("lda", LDA, 1'b0);
    exp_seq = '{S_EP | S_LM, S_CP, S_CE | S_LI, S_EI | S_LM, S_CE | S_LB, S_EU | S_LA};
    run_instr("add", ADD, 1'b0);
    exp_seq = '{S_EP | S_LM, S_CP, S_CE | S_LI, S_EI | S_LM, S_CE | S_LB, S_EU | S_SU | S_LA};
    run_instr("sub", SUB, 1'b0);
    exp_seq = '{S_EP | S_LM, S_CP, S_CE | S_LI, S_EA | S_LO, 12'd0, 12'd0};
    run_instr("out", OUT, 1'b1);
    exp_seq = '{S_EP | S_LM, S_CP, S_CE | S_LI, 12'd0, 12'd0, 12'd0};
    run_instr("nop", NOP, 1'b1);

    // HLT: fetch with scrambled opcode, then HLT at the edge entering T4
    for (int i = 0; i < 3; i++) cycle(1'b0, 4'($urandom_range(0, 14)));
    cycle(1'b0, HLT);
    chk("hlt_halted", {31'd0, halted}, 32'd1);
    chk("hlt_t_state", {26'd0, t_state}, 32'b001000);
    chk("hlt_strobes", {20'd0, w_act}, 32'd0);
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 4'($urandom_range(0, 15)));
      chk("hlt_hold_t_state", {26'd0, t_state}, 32'b001000);
      chk("hlt_hold_strobes", {20'd0, w_act}, 32'd0);
      chk("hlt_hold_halted", {31'd0, halted}, 32'd1);
    end
    cycle(1'b1, LDA);
    chk("hlt_clr_t_state", {26'd0, t_state}, 32'd0);
    chk("hlt_clr_halted", {31'd0, halted}, 32'd0);

    // reset at the edge that would enter T5 of ADD
    for (int i = 0; i < 4; i++) cycle(1'b0, ADD);
    chk("mid_t4_t_state", {26'd0, t_state}, 32'b001000);
    cycle(1'b1, ADD);
    chk("mid_rst_t_state", {26'd0, t_state}, 32'd0);
    chk("mid_rst_strobes", {20'd0, w_act}, 32'd0);
    cycle(1'b0, ADD);
    chk("mid_rel_t_state", {26'd0, t_state}, 32'b000001);
    chk("mid_rel_strobes", {20'd0, w_act}, {20'd0, S_EP | S_LM});

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] op;
      int r;
      r = $urandom_range(0, 9);
      if (r < 6) op = 4'($urandom_range(0, 2));
      else if (r < 8) op = OUT;
      else op = 4'($urandom_range(0, 15));
      cycle(($urandom_range(0, 39) == 0), op);
    end

    clear = 1'b0;
    @(posedge clock);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
